// File: rtl/sap1_pkg.sv
// Shared types and helpers for the SAP-1 memory subsystem: loader FSM states
// and the SRAM depth function.
package sap1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    VERIFY,
    NEXT,
    DONE
  } loader_state_e;

  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/sram_addr_counter.sv
// Modulo-depth SRAM address counter with synchronous clear, increment and a
// flag marking the final address of the array.
module sram_addr_counter
  import sap1_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_bar,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] cnt,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == ADDR_WIDTH'(depth(ADDR_WIDTH) - 1));

endmodule

// File: rtl/sram_loader.sv
// Programming-side SRAM initiator: writes handshaked bytes to consecutive
// addresses with read-back verify, and yields the SRAM port to the CPU in run mode.
module sram_loader
  import sap1_pkg::*;
#(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int WE_PULSE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_bar,
  input  logic                  run_not_prog,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  done,
  output logic                  verify_err,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_ce_bar,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  ce_bar,
  output logic                  we_bar,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  localparam int PW = (WE_PULSE_CYCLES > 1) ? $clog2(WE_PULSE_CYCLES) : 1;

  loader_state_e         state_q, state_d;
  logic                  run_q, run_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [PW-1:0]         pulse_q, pulse_d;

  logic                  rearm;
  logic                  accept;
  logic                  pulse_last;
  logic                  cnt_inc;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  cnt_last;

  assign rearm      = run_q & ~run_not_prog;
  assign accept     = load_valid & load_ready;
  assign pulse_last = (pulse_q == PW'(WE_PULSE_CYCLES - 1));
  assign cnt_inc    = ~run_not_prog & (state_q == NEXT);

  sram_addr_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_counter (
    .clk     (clk),
    .rst_bar (rst_bar),
    .clr     (rearm),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .last    (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (run_not_prog || rearm) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = SETUP;
        SETUP:   state_d = WRITE;
        WRITE:   if (pulse_last) state_d = HOLD;
        HOLD:    state_d = VERIFY;
        VERIFY:  state_d = NEXT;
        NEXT:    state_d = cnt_last ? DONE : IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Run mode owns the SRAM port combinationally so a mode switch cuts any write pulse at once.
  always_comb begin
    load_ready = 1'b0;
    ce_bar     = 1'b1;
    we_bar     = 1'b1;
    addr       = cnt;
    wr_data    = wr_data_q;
    if (run_not_prog) begin
      addr   = cpu_addr;
      ce_bar = cpu_ce_bar;
    end else begin
      load_ready = (state_q == IDLE) && !done_q && !rearm;
      ce_bar     = !(state_q inside {SETUP, WRITE, HOLD, VERIFY});
      we_bar     = (state_q != WRITE);
    end
    if (!rst_bar) begin
      load_ready = 1'b0;
      ce_bar     = 1'b1;
      we_bar     = 1'b1;
    end
  end

  always_comb begin
    run_d      = run_not_prog;
    wr_data_d  = accept ? load_data : wr_data_q;
    pulse_d    = (state_q == WRITE) ? pulse_q + PW'(1) : '0;
    done_d     = done_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (rearm) begin
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_addr_d = '0;
    end else if (!run_not_prog) begin
      if (state_q == NEXT && cnt_last) begin
        done_d = 1'b1;
      end
      // Only the first mismatch address is kept; later ones just keep the sticky flag set.
      if (state_q == VERIFY && rd_data != wr_data_q) begin
        err_d = 1'b1;
        if (!err_q) begin
          err_addr_d = cnt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      run_q      <= 1'b0;
      wr_data_q  <= '0;
      pulse_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      run_q      <= run_d;
      wr_data_q  <= wr_data_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign done        = done_q;
  assign verify_err  = err_q;
  assign err_addr    = err_addr_q;
  assign cpu_rd_data = rd_data;

endmodule

// File: tb/tb_sram_loader.sv
// Directed bench for sram_loader: two instances (1- and 3-cycle write pulse)
// share one SRAM model with optional read-fault injection.
module tb_sram_loader;

  logic       clk = 1'b0;
  logic       rst1, rst3;
  logic       run_not_prog, load_valid, cpu_ce_bar;
  logic [7:0] load_data;
  logic [3:0] cpu_addr;
  logic [7:0] rd_data;

  logic       lr1, done1, ve1, ce1, we1;
  logic [3:0] ea1, a1;
  logic [7:0] crd1, wd1;
  logic       lr3, done3, ve3, ce3, we3;
  logic [3:0] ea3, a3;
  logic [7:0] crd3, wd3;

  logic       sel;
  logic       lr_s, done_s, ve_s, ce_s, we_s;
  logic [3:0] ea_s, addr_s;
  logic [7:0] wd_s;

  logic [7:0]  mem [16];
  logic [7:0]  exp_mem [16];
  logic [15:0] fault_mask;
  logic [3:0]  exp_addr;
  int          cur_w;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WE_PULSE_CYCLES(1)) dut1 (
    .clk(clk), .rst_bar(rst1), .run_not_prog(run_not_prog),
    .load_valid(load_valid), .load_data(load_data), .load_ready(lr1),
    .done(done1), .verify_err(ve1), .err_addr(ea1),
    .cpu_addr(cpu_addr), .cpu_ce_bar(cpu_ce_bar), .cpu_rd_data(crd1),
    .ce_bar(ce1), .we_bar(we1), .addr(a1), .wr_data(wd1), .rd_data(rd_data)
  );

  sram_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WE_PULSE_CYCLES(3)) dut3 (
    .clk(clk), .rst_bar(rst3), .run_not_prog(run_not_prog),
    .load_valid(load_valid), .load_data(load_data), .load_ready(lr3),
    .done(done3), .verify_err(ve3), .err_addr(ea3),
    .cpu_addr(cpu_addr), .cpu_ce_bar(cpu_ce_bar), .cpu_rd_data(crd3),
    .ce_bar(ce3), .we_bar(we3), .addr(a3), .wr_data(wd3), .rd_data(rd_data)
  );

  assign lr_s   = sel ? lr3   : lr1;
  assign done_s = sel ? done3 : done1;
  assign ve_s   = sel ? ve3   : ve1;
  assign ea_s   = sel ? ea3   : ea1;
  assign ce_s   = sel ? ce3   : ce1;
  assign we_s   = sel ? we3   : we1;
  assign addr_s = sel ? a3    : a1;
  assign wd_s   = sel ? wd3   : wd1;

  assign rd_data = fault_mask[addr_s] ? 8'hFF : mem[addr_s];

  always @(posedge clk) begin
    if (!ce_s && !we_s) mem[addr_s] <= wd_s;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gen(input int mode, input logic [7:0] base, input int idx);
    if (mode == 0) return base + 8'(idx);
    return 8'($urandom_range(0, 254));
  endfunction

  // Streams n bytes back-to-back, checking handshake period and we_bar pulse
  // widths; returns in the NEXT cycle of the last byte.
  task automatic prog_bytes(input int n, input int mode, input logic [7:0] base);
    int idx = 0, cyc = 0, last_acc = -1, run = 0, pulses = 0;
    bit acc;
    load_data  = gen(mode, base, 0);
    load_valid = 1'b1;
    while (idx < n && cyc < 3000) begin
      if (!we_s) run++;
      else if (run != 0) begin
        chk("we_width", run, cur_w);
        pulses++;
        run = 0;
      end
      acc = lr_s && load_valid;
      if (acc) begin
        exp_mem[exp_addr] = load_data;
        if (last_acc >= 0) chk("ready_period", cyc - last_acc, 5 + cur_w);
        last_acc = cyc;
        $display("tb: byte %0d addr %0d data %02h accepted at cycle %0d", idx, exp_addr, load_data, cyc);
      end
      step();
      cyc++;
      if (acc) begin
        idx++;
        exp_addr++;
        load_data = gen(mode, base, idx);
      end
    end
    load_valid = 1'b0;
    chk("bytes_accepted", idx, n);
    for (int k = 0; k < 3 + cur_w; k++) begin
      if (!we_s) run++;
      else if (run != 0) begin
        chk("we_width", run, cur_w);
        pulses++;
        run = 0;
      end
      step();
    end
    chk("we_pulses", pulses, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b0; rst3 = 1'b0; sel = 1'b0; cur_w = 1;
    run_not_prog = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    cpu_addr = 4'h0; cpu_ce_bar = 1'b1; fault_mask = 16'h0; exp_addr = 4'h0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end

    // Reset state
    repeat (2) step();
    chk("rst_ce_bar", ce_s, 1);
    chk("rst_we_bar", we_s, 1);
    chk("rst_load_ready", lr_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_verify_err", ve_s, 0);
    chk("rst_err_addr", ea_s, 0);
    rst1 = 1'b1;
    step();
    chk("first_ready", lr_s, 1);

    // Full load of 0x10..0x1F
    prog_bytes(16, 0, 8'h10);
    chk("done_before_last_next", done_s, 0);
    step();
    chk("done_after_last_next", done_s, 1);
    chk("verify_err_clean", ve_s, 0);
    chk("ready_after_done", lr_s, 0);
    for (int i = 0; i < 16; i++) chk("mem_load", mem[i], 8'h10 + 8'(i));

    // Writes ignored once done
    load_data = 8'hAA;
    load_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("ready_held_low", lr_s, 0);
      chk("no_we_after_done", we_s, 1);
      step();
    end
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) chk("mem_unchanged", mem[i], exp_mem[i]);

    // Re-arm then random data with read faults at 5 and 9
    run_not_prog = 1'b1;
    step();
    chk("run_ready_low", lr_s, 0);
    run_not_prog = 1'b0;
    step();
    chk("rearm_done", done_s, 0);
    chk("rearm_ready", lr_s, 1);
    exp_addr = 4'h0;
    fault_mask = 16'h0220;
    prog_bytes(16, 1, 8'h00);
    step();
    chk("fault_done", done_s, 1);
    chk("fault_verify_err", ve_s, 1);
    chk("fault_err_addr", ea_s, 5);
    fault_mask = 16'h0;

    // Mode switch in the middle of the write to address 3
    run_not_prog = 1'b1;
    step();
    run_not_prog = 1'b0;
    step();
    chk("rearm2_verify_err", ve_s, 0);
    chk("rearm2_err_addr", ea_s, 0);
    exp_addr = 4'h0;
    prog_bytes(3, 0, 8'h30);
    step();
    load_data = 8'h55;
    load_valid = 1'b1;
    begin
      int t = 0;
      while (we_s !== 1'b0 && t < 20) begin
        step();
        t++;
      end
      chk("reach_write_a3", t < 20, 1);
    end
    chk("write_addr_a3", addr_s, 3);
    run_not_prog = 1'b1;
    #1;
    chk("switch_we_high", we_s, 1);
    load_valid = 1'b0;
    cpu_addr = 4'h3;
    cpu_ce_bar = 1'b0;
    #1;
    chk("cpu_addr_mux", addr_s, 3);
    chk("cpu_ce_mux", ce_s, 0);
    chk("cpu_rd_old_word", crd1, exp_mem[3]);
    step();
    chk("run_ready_low2", lr_s, 0);
    chk("mem3_not_written", mem[3], exp_mem[3]);
    cpu_ce_bar = 1'b1;
    run_not_prog = 1'b0;
    step();
    chk("rearm3_done", done_s, 0);
    chk("rearm3_ready", lr_s, 1);
    chk("rearm3_addr", addr_s, 0);
    exp_addr = 4'h0;
    prog_bytes(1, 0, 8'h77);
    chk("restart_addr0", mem[0], 8'h77);

    // 3-cycle write pulse instance with reset during a write
    rst1 = 1'b0;
    sel = 1'b1;
    cur_w = 3;
    rst3 = 1'b1;
    step();
    chk("w3_first_ready", lr_s, 1);
    exp_addr = 4'h0;
    prog_bytes(1, 0, 8'h40);
    step();
    load_data = 8'h41;
    load_valid = 1'b1;
    begin
      int t = 0;
      while (we_s !== 1'b0 && t < 20) begin
        step();
        t++;
      end
      chk("w3_reach_write", t < 20, 1);
    end
    step();
    chk("w3_second_write_we", we_s, 0);
    chk("w3_second_write_addr", addr_s, 1);
    rst3 = 1'b0;
    #1;
    chk("w3_rst_ce_bar", ce_s, 1);
    chk("w3_rst_we_bar", we_s, 1);
    chk("w3_rst_addr", addr_s, 0);
    chk("w3_rst_ready", lr_s, 0);
    load_valid = 1'b0;
    step();
    rst3 = 1'b1;
    step();
    chk("w3_ready_after_rst", lr_s, 1);
    chk("w3_done_after_rst", done_s, 0);
    exp_addr = 4'h0;
    prog_bytes(3, 0, 8'h50);
    for (int i = 0; i < 3; i++) chk("w3_mem", mem[i], 8'h50 + 8'(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
